imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the decode-stage immediate extender: packs a 32-bit immediate plus register, funct and opcode fields into a 32-bit RV32I instruction word.
- Used by the self-test/boot sequencer and the testbench instruction generator.
- Two-stage valid/ready pipeline: accepts 1 op/cycle, 2-cycle latency, full backpressure.
- Flags immediates that the selected format cannot represent.

Parameters:
- ERR_CNT_W, 16, width of saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- imm_sel  in  3  000 I, 001 S, 010 B, 011 U, 100 J; 101-111 illegal.
- imm  in  32  immediate, byte offset for B/J.
- opcode  in  7  placed in instr[6:0].
- funct3  in  3  instr[14:12] (I/S/B only).
- funct7  in  7  instr[31:25]; used only when imm_sel=I and funct3 is 001 or 101 (shifts).
- rd  in  5  instr[11:7] (I/U/J).
- rs1  in  5  instr[19:15] (I/S/B).
- rs2  in  5  instr[24:20] (S/B).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- instr  out  32  encoded instruction.
- imm_err  out  1  immediate not representable or imm_sel illegal; qualified by out_valid.
- err_cnt  out  ERR_CNT_W  count of errored results delivered.

Behaviour:
- Reset (rst_n=0 at posedge): s1_valid=0, s2_valid=0, out_valid=0, instr=0, imm_err=0, err_cnt=0. In-flight ops are dropped. in_ready=1 in the first cycle after reset.
- Stage 1 (S1) registers the inputs and computes the range check.
- Stage 2 (S2) holds the assembled instr and imm_err. out_valid = s2_valid.
- Stage advance:
  - S2 loads when !s2_valid || out_ready.
  - S1 loads when !s1_valid || S2 loads.
  - in_ready = !s1_valid || S2 loads (combinational from out_ready).
- Output hold: outputs stay stable while out_valid && !out_ready. No bubbles under continuous flow. Order is preserved.
- Encoding:
  - I: {imm[11:0], rs1, funct3, rd, opcode}. For the shift case, instr[31:25] = funct7 and imm[4:0] fills [24:20].
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - Illegal imm_sel: instr = 32'h0000_0000.
- imm_err = 1 when any of these holds:
  - I/S: imm[31:11] not all equal.
  - I shift: imm[31:5] != 0.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - U: imm[11:0] != 0.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - imm_sel illegal.
- Errored ops are still encoded: the field slices above are taken and the excess bits are dropped.
- err_cnt increments on out_valid && out_ready && imm_err. It saturates at all-ones.

Optional Feature:
- Macro: IMM_ENCODER_ROUNDTRIP_EN.
- Defined:
  - S2 re-decodes instr with the extender's sign-extension rules, where U = {instr[31:12], 12'b0}.
  - Adds output rt_mismatch (1 bit, reset 0), asserted with out_valid when !imm_err and the decoded value != the registered imm.
  - This must never fire for legal input.
- Undefined: port and logic are absent. Behaviour is otherwise identical.

Test Plan:
- I addi: opcode=0x13, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF, out_ready=1 -> 2 cycles later instr=0xFFF00093, imm_err=0.
- S sw: opcode=0x23, funct3=2, rs1=1, rs2=2, imm=8 -> instr=0x0020A423. B beq: opcode=0x63, rs1=rs2=0, imm=0xFFFFFFFC -> instr=0xFE000EE3.
- J jal: opcode=0x6F, rd=1, imm=0x800 -> instr=0x001000EF. U lui: opcode=0x37, rd=5, imm=0x12345000 -> instr=0x123452B7.
- Errors:
  - B imm=5, U imm=0x12345678, imm_sel=3'b110 each -> imm_err=1 and err_cnt goes 0->1->2->3.
  - With ERR_CNT_W=2, five errors -> err_cnt holds 3.
- Backpressure: out_ready=0 with 4 back-to-back inputs -> only 2 accepted, then in_ready=0 and instr held stable. Raising out_ready -> results emerge in order with no loss or duplication.
- Reset mid-flight: 2 ops in pipe, rst_n=0 for one edge -> out_valid=0, err_cnt=0, in_ready=1 next cycle, and the old ops never appear.

Source files
------------

// File: rtl/imm_encoder_if.sv
// Request/response bus of the immediate encoder.
// The master drives requests and out_ready; the slave returns the encoded word.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_sel;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        imm_err;

  modport master (
    output in_valid, imm_sel, imm, opcode,
    output funct3, funct7, rd, rs1, rs2,
    output out_ready,
    input  in_ready, out_valid, instr, imm_err
  );

  modport slave (
    input  in_valid, imm_sel, imm, opcode,
    input  funct3, funct7, rd, rs1, rs2,
    input  out_ready,
    output in_ready, out_valid, instr, imm_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage RV32I immediate encoder with range checking and error counter.
// Define IMM_ENCODER_ROUNDTRIP_EN to add the rt_mismatch re-decode check.
module imm_encoder #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imm_encoder_if.slave         bus,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef IMM_ENCODER_ROUNDTRIP_EN
  ,
  output logic                 rt_mismatch
`endif
);

  localparam logic [2:0] SEL_I = 3'd0;
  localparam logic [2:0] SEL_S = 3'd1;
  localparam logic [2:0] SEL_B = 3'd2;
  localparam logic [2:0] SEL_U = 3'd3;
  localparam logic [2:0] SEL_J = 3'd4;

  logic        w_s1_load;
  logic        w_s2_load;
  logic        w_shift;
  logic        w_err;
  logic [31:0] w_instr;

  logic        r_s1_valid;
  logic        r_s1_err;
  logic        r_s1_shift;
  logic [2:0]  r_s1_sel;
  logic [31:0] r_s1_imm;
  logic [6:0]  r_s1_op;
  logic [2:0]  r_s1_f3;
  logic [6:0]  r_s1_f7;
  logic [4:0]  r_s1_rd;
  logic [4:0]  r_s1_rs1;
  logic [4:0]  r_s1_rs2;

  logic        r_s2_valid;
  logic        r_s2_err;
  logic [31:0] r_s2_instr;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  function automatic logic sext_ok(
    input logic [31:0] v,
    input int unsigned lo
  );
    logic [31:0] m;
    m = 32'hFFFF_FFFF << lo;
    return ((v & m) == m) || ((v & m) == 32'h0);
  endfunction

  assign w_s2_load    = !r_s2_valid || bus.out_ready;
  assign w_s1_load    = !r_s1_valid || w_s2_load;
  assign bus.in_ready = w_s1_load;

  // funct3 001/101 are the I-type shifts
  assign w_shift = (bus.imm_sel == SEL_I) &&
                   (bus.funct3[1:0] == 2'b01);

  always_comb begin
    w_err = 1'b1;
    unique case (bus.imm_sel)
      SEL_I: w_err = w_shift ? |bus.imm[31:5]
                             : !sext_ok(bus.imm, 11);
      SEL_S: w_err = !sext_ok(bus.imm, 11);
      SEL_B: w_err = !sext_ok(bus.imm, 12) || bus.imm[0];
      SEL_U: w_err = |bus.imm[11:0];
      SEL_J: w_err = !sext_ok(bus.imm, 20) || bus.imm[0];
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_err   <= w_err;
        r_s1_shift <= w_shift;
        r_s1_sel   <= bus.imm_sel;
        r_s1_imm   <= bus.imm;
        r_s1_op    <= bus.opcode;
        r_s1_f3    <= bus.funct3;
        r_s1_f7    <= bus.funct7;
        r_s1_rd    <= bus.rd;
        r_s1_rs1   <= bus.rs1;
        r_s1_rs2   <= bus.rs2;
      end
    end
  end

  always_comb begin
    w_instr = 32'h0;
    unique case (r_s1_sel)
      SEL_I: w_instr = r_s1_shift
        ? {r_s1_f7, r_s1_imm[4:0], r_s1_rs1,
           r_s1_f3, r_s1_rd, r_s1_op}
        : {r_s1_imm[11:0], r_s1_rs1,
           r_s1_f3, r_s1_rd, r_s1_op};
      SEL_S: w_instr = {r_s1_imm[11:5], r_s1_rs2,
                        r_s1_rs1, r_s1_f3,
                        r_s1_imm[4:0], r_s1_op};
      SEL_B: w_instr = {r_s1_imm[12], r_s1_imm[10:5],
                        r_s1_rs2, r_s1_rs1, r_s1_f3,
                        r_s1_imm[4:1], r_s1_imm[11],
                        r_s1_op};
      SEL_U: w_instr = {r_s1_imm[31:12], r_s1_rd,
                        r_s1_op};
      SEL_J: w_instr = {r_s1_imm[20], r_s1_imm[10:1],
                        r_s1_imm[11], r_s1_imm[19:12],
                        r_s1_rd, r_s1_op};
      default: w_instr = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_err   <= 1'b0;
      r_s2_instr <= 32'h0;
      r_err_cnt  <= '0;
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_instr <= w_instr;
          r_s2_err   <= r_s1_err;
        end
      end
      if (r_s2_valid && bus.out_ready &&
          r_s2_err && !(&r_err_cnt)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.instr     = r_s2_instr;
  assign bus.imm_err   = r_s2_err;
  assign err_cnt       = r_err_cnt;

`ifdef IMM_ENCODER_ROUNDTRIP_EN
  logic [2:0]  r_s2_sel;
  logic [31:0] r_s2_imm;
  logic        r_s2_shift;
  logic [31:0] w_dec;

  always_ff @(posedge clk) begin
    if (w_s2_load && r_s1_valid) begin
      r_s2_sel   <= r_s1_sel;
      r_s2_imm   <= r_s1_imm;
      r_s2_shift <= r_s1_shift;
    end
  end

  // shift amounts decode unsigned; funct7 is not part of the value
  always_comb begin
    w_dec = 32'h0;
    unique case (r_s2_sel)
      SEL_I: w_dec = r_s2_shift
        ? {27'h0, r_s2_instr[24:20]}
        : {{20{r_s2_instr[31]}}, r_s2_instr[31:20]};
      SEL_S: w_dec = {{20{r_s2_instr[31]}},
                      r_s2_instr[31:25], r_s2_instr[11:7]};
      SEL_B: w_dec = {{19{r_s2_instr[31]}}, r_s2_instr[31],
                      r_s2_instr[7], r_s2_instr[30:25],
                      r_s2_instr[11:8], 1'b0};
      SEL_U: w_dec = {r_s2_instr[31:12], 12'h0};
      SEL_J: w_dec = {{11{r_s2_instr[31]}}, r_s2_instr[31],
                      r_s2_instr[19:12], r_s2_instr[20],
                      r_s2_instr[30:21], 1'b0};
      default: w_dec = 32'h0;
    endcase
  end

  assign rt_mismatch = r_s2_valid && !r_s2_err &&
                       (w_dec != r_s2_imm);
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder.
// Scoreboard fed by an arithmetic model of the instruction formats.
module tb_imm_encoder;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_encoder_if bus ();
  imm_encoder_if bus2 ();
  logic [15:0] err_cnt;
  logic [1:0]  err_cnt2;
`ifdef IMM_ENCODER_ROUNDTRIP_EN
  logic rt_mismatch;
  logic rt_mismatch2;
`endif

  imm_encoder #(.ERR_CNT_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .err_cnt(err_cnt)
`ifdef IMM_ENCODER_ROUNDTRIP_EN
    ,
    .rt_mismatch(rt_mismatch)
`endif
  );

  imm_encoder #(.ERR_CNT_W(2)) dut2 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus2),
    .err_cnt(err_cnt2)
`ifdef IMM_ENCODER_ROUNDTRIP_EN
    ,
    .rt_mismatch(rt_mismatch2)
`endif
  );

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  int   exp_cnt = 0;
  bit   hold_v = 0;
  logic [31:0] hold_i;
  logic        hold_e;
  logic [31:0] last_instr;
  logic        last_err;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t model(
    input logic [2:0]  sel,
    input logic [31:0] imm,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2
  );
    longint s;
    logic [31:0] w;
    logic [31:0] o, d, r1, r2, fn;
    bit ok;
    exp_t e;
    s  = longint'($signed(imm));
    o  = 32'(op);
    d  = 32'(rd) << 7;
    r1 = 32'(rs1) << 15;
    r2 = 32'(rs2) << 20;
    fn = 32'(f3) << 12;
    case (sel)
      3'd0: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          ok = (imm < 32);
          w  = (32'(f7) << 25) | ((imm % 32) << 20)
             | r1 | fn | d | o;
        end else begin
          ok = (s >= -2048 && s <= 2047);
          w  = ((imm % 4096) << 20) | r1 | fn | d | o;
        end
      end
      3'd1: begin
        ok = (s >= -2048 && s <= 2047);
        w  = (((imm >> 5) % 128) << 25) | r2 | r1 | fn
           | ((imm % 32) << 7) | o;
      end
      3'd2: begin
        ok = (s >= -4096 && s <= 4095) && (imm % 2 == 0);
        w  = (((imm >> 12) & 1) << 31)
           | (((imm >> 5) % 64) << 25) | r2 | r1 | fn
           | (((imm >> 1) % 16) << 8)
           | (((imm >> 11) & 1) << 7) | o;
      end
      3'd3: begin
        ok = (imm % 4096 == 0);
        w  = (imm - (imm % 4096)) | d | o;
      end
      3'd4: begin
        ok = (s >= -1048576 && s <= 1048575) &&
             (imm % 2 == 0);
        w  = (((imm >> 20) & 1) << 31)
           | (((imm >> 1) % 1024) << 21)
           | (((imm >> 11) & 1) << 20)
           | (((imm >> 12) % 256) << 12) | d | o;
      end
      default: begin
        ok = 0;
        w  = 32'h0;
      end
    endcase
    e.instr = w;
    e.err   = !ok;
    return e;
  endfunction

  task automatic tick(output bit acc);
    exp_t e;
    #1;
    chk("err_cnt", 32'(err_cnt), exp_cnt);
    if (hold_v && bus.out_valid) begin
      chk("hold_instr", bus.instr, hold_i);
      chk("hold_err", 32'(bus.imm_err), 32'(hold_e));
    end
`ifdef IMM_ENCODER_ROUNDTRIP_EN
    if (bus.out_valid)
      chk("rt_mismatch", 32'(rt_mismatch), 0);
`endif
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 32'(bus.out_valid), 0);
      end else begin
        e = q.pop_front();
        chk("instr", bus.instr, e.instr);
        chk("imm_err", 32'(bus.imm_err), 32'(e.err));
        last_instr = bus.instr;
        last_err   = bus.imm_err;
        if (e.err && exp_cnt < 65535) exp_cnt++;
      end
    end
    hold_v = bus.out_valid && !bus.out_ready;
    hold_i = bus.instr;
    hold_e = bus.imm_err;
    acc = bus.in_valid && bus.in_ready;
    if (acc)
      q.push_back(model(bus.imm_sel, bus.imm, bus.opcode,
                        bus.funct3, bus.funct7, bus.rd,
                        bus.rs1, bus.rs2));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    bit acc;
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      tick(acc);
      n++;
    end
    chk(tag, 32'(q.size()), 0);
  endtask

  task automatic send(input logic [2:0]  sel,
                      input logic [31:0] imm,
                      input logic [6:0]  op,
                      input logic [2:0]  f3,
                      input logic [4:0]  rd,
                      input logic [4:0]  rs1,
                      input logic [4:0]  rs2);
    bit acc = 0;
    int n = 0;
    bus.imm_sel   = sel;
    bus.imm       = imm;
    bus.opcode    = op;
    bus.funct3    = f3;
    bus.funct7    = 7'h0;
    bus.rd        = rd;
    bus.rs1       = rs1;
    bus.rs2       = rs2;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    chk("send_accept", 32'(acc), 1);
    bus.in_valid = 1'b0;
    drain("send_drain");
  endtask

  task automatic rand_ops();
    logic [31:0] r;
    r = $urandom;
    bus.imm_sel = ($urandom_range(0, 3) == 0)
                  ? 3'($urandom_range(0, 7))
                  : 3'($urandom_range(0, 4));
    case ($urandom_range(0, 4))
      0: bus.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      1: bus.imm = r;
      2: bus.imm = r & 32'hFFFF_F000;
      3: bus.imm = 32'($urandom_range(0, 40));
      default: bus.imm = {{11{r[20]}}, r[20:1], 1'b0};
    endcase
    bus.opcode = 7'($urandom);
    bus.funct3 = 3'($urandom);
    bus.funct7 = 7'($urandom);
    bus.rd     = 5'($urandom);
    bus.rs1    = 5'($urandom);
    bus.rs2    = 5'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int nacc;
    rst_n = 1'b0;
    bus.in_valid = 0; bus.out_ready = 0;
    bus.imm_sel = 0; bus.imm = 0; bus.opcode = 0;
    bus.funct3 = 0; bus.funct7 = 0;
    bus.rd = 0; bus.rs1 = 0; bus.rs2 = 0;
    bus2.in_valid = 0; bus2.out_ready = 0;
    bus2.imm_sel = 0; bus2.imm = 0; bus2.opcode = 0;
    bus2.funct3 = 0; bus2.funct7 = 0;
    bus2.rd = 0; bus2.rs1 = 0; bus2.rs2 = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_imm_err", 32'(bus.imm_err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    send(3'd0, 32'hFFFF_FFFF, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0);
    chk("addi", last_instr, 32'hFFF0_0093);
    chk("addi_err", 32'(last_err), 0);
    send(3'd1, 32'd8, 7'h23, 3'd2, 5'd0, 5'd1, 5'd2);
    chk("sw", last_instr, 32'h0020_A423);
    send(3'd2, 32'hFFFF_FFFC, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0);
    chk("beq", last_instr, 32'hFE00_0EE3);
    send(3'd4, 32'h0000_0800, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0);
    chk("jal", last_instr, 32'h0010_00EF);
    send(3'd3, 32'h1234_5000, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0);
    chk("lui", last_instr, 32'h1234_52B7);
    chk("lui_err", 32'(last_err), 0);

    send(3'd2, 32'd5, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0);
    chk("b_odd_err", 32'(last_err), 1);
    chk("cnt1", 32'(err_cnt), 1);
    send(3'd3, 32'h1234_5678, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0);
    chk("u_low_err", 32'(last_err), 1);
    chk("cnt2", 32'(err_cnt), 2);
    send(3'b110, 32'h0, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0);
    chk("sel_err", 32'(last_err), 1);
    chk("sel_instr", last_instr, 32'h0);
    chk("cnt3", 32'(err_cnt), 3);

    bus.out_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      bus.in_valid = 1'b1;
      tick(acc);
      if (acc) nacc++;
    end
    bus.in_valid = 1'b0;
    chk("bp_accepted", 32'(nacc), 2);
    chk("bp_in_ready", 32'(bus.in_ready), 0);
    chk("bp_out_valid", 32'(bus.out_valid), 1);
    repeat (3) tick(acc);
    bus.out_ready = 1'b1;
    drain("bp_drain");

    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_ops();
      bus.in_valid = 1'b1;
      tick(acc);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    hold_v  = 0;
    exp_cnt = 0;
    chk("mrst_out_valid", 32'(bus.out_valid), 0);
    chk("mrst_err_cnt", 32'(err_cnt), 0);
    chk("mrst_in_ready", 32'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    repeat (5) tick(acc);

    for (int i = 0; i < 500; i++) begin
      rand_ops();
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      tick(acc);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain("rand_drain");

    bus2.imm_sel   = 3'b111;
    bus2.out_ready = 1'b1;
    bus2.in_valid  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("sat_err_cnt", 32'(err_cnt2), 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
